// File: rtl/hd44780_bus_writer.sv
// HD44780 bus writer: decodes sequencer tokens into LCD bytes, queues them in
// a small FIFO and drives the 8-bit HD44780 bus with the required
// setup, E-high, hold and execution-time spacing.
module hd44780_bus_writer #(
    parameter int SETUP_CYC  = 4,
    parameter int E_HIGH_CYC = 30,
    parameter int HOLD_CYC   = 4,
    parameter int EXEC_CYC   = 4000,
    parameter int CLEAR_CYC  = 160000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ena,
    input  logic       i_trigger,
    input  logic       i_data,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_val,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > CLEAR_CYC) ? MAX_C : CLEAR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EHIGH = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;

    // Clear-display is the only command with the long execution time.
    localparam logic [8:0] CLEAR_WORD = {1'b0, 8'h01};

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_is_clear;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             dec_valid;
    logic [8:0]       dec_word;
    logic             accept;
    logic             full;
    logic             push;
    logic             pop;
    logic [8:0]       head;

    assign o_lcd_rw = 1'b0;

    // Token decode into {rs, byte}; unknown command selectors are discarded.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        dec_valid = 1'b0;
        dec_word  = 9'h000;
        if (!i_data) begin
            dec_valid = 1'b1;
            case (i_sel)
                3'b100:  dec_word = {1'b0, 8'h38};
                3'b101:  dec_word = {1'b0, 8'h0C};
                3'b110:  dec_word = {1'b0, 8'h01};
                3'b111:  dec_word = {1'b0, 8'h06};
                3'b000:  dec_word = {1'b0, 4'h8, i_val};
                default: dec_valid = 1'b0;
            endcase
        end else begin
            dec_valid = 1'b1;
            case (i_sel[1:0])
                2'b00:   dec_word = {1'b1, (i_val <= 4'd9) ? (8'h30 + {4'b0, i_val}) : 8'h3F};
                2'b01:   dec_word = {1'b1, i_val[0] ? 8'h20 : 8'h3A};
                2'b11:   dec_word = {1'b1, i_val[0] ? 8'h50 : 8'h41};
                default: dec_word = {1'b1, 8'h4D};
            endcase
        end
    end

    assign accept = i_ena && i_trigger && dec_valid;
    assign full   = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop    = (state == S_IDLE) && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push   = accept && (!full || pop);
    assign head   = mem[rd_ptr];

    // Token FIFO: storage, pointers and occupancy.
    // NOTE: the storage is tiny, so it is reset along with the pointers to
    // keep every flop at a known value after reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (push) begin
                mem[wr_ptr] <= dec_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for tokens dropped because the FIFO had no room.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_overflow <= 1'b0;
        else if (accept && !push) o_overflow <= 1'b1;
    end

    // Bus FSM: one down-counter times every phase of a write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cur_is_clear <= 1'b0;
            o_lcd_e      <= 1'b0;
            o_lcd_rs     <= 1'b0;
            o_lcd_db     <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_lcd_rs     <= head[8];
                        o_lcd_db     <= head[7:0];
                        cur_is_clear <= (head == CLEAR_WORD);
                        cnt          <= CNT_W'(SETUP_CYC - 1);
                        state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        o_lcd_e <= 1'b1;
                        cnt     <= CNT_W'(E_HIGH_CYC - 1);
                        state   <= S_EHIGH;
                    end else cnt <= cnt - 1'b1;
                end
                S_EHIGH: begin
                    if (cnt == '0) begin
                        o_lcd_e <= 1'b0;
                        cnt     <= CNT_W'(HOLD_CYC - 1);
                        state   <= S_HOLD;
                    end else cnt <= cnt - 1'b1;
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= cur_is_clear ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
                        state <= S_EXEC;
                    end else cnt <= cnt - 1'b1;
                end
                S_EXEC: begin
                    if (cnt == '0) state <= S_IDLE;
                    else cnt <= cnt - 1'b1;
                end
                default: begin
                    o_lcd_e <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Registered busy: pending tokens or a write still in progress.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_busy <= 1'b0;
        else o_busy <= (count != '0) || (state != S_IDLE);
    end

endmodule
